pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter NSTAGES, default 3: scoreboard depth, i.e. stages after ID (EXE, MEM, WB); legal range 2..8.
REQ-002 SHALL have parameter REG_ADDR_LEN, default 5: register address width.
REQ-003 SHALL have parameter FWD_EN, default 1: 1 = forwarding mode, 0 = stall-only mode.
REQ-004 SHALL have `clk`  in  1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have `rst_n`  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have `id_valid`  in  1: the ID stage holds a real instruction.
REQ-007 SHALL have `id_rs1`, `id_rs2`  in  REG_ADDR_LEN each: source registers of the ID instruction.
REQ-008 SHALL have `id_rs1_en`, `id_rs2_en`  in  1 each: the corresponding source is read.
REQ-009 SHALL have `id_rd`  in  REG_ADDR_LEN: destination register; `id_rd_en`  in  1: the instruction writes id_rd.
REQ-010 SHALL have `id_is_load`, `id_is_halt`  in  1 each: ID instruction class flags.
REQ-011 SHALL have `exe_br_taken`  in  1: the instruction in EXE redirects the PC.
REQ-012 SHALL have `stall`  out  1: hold IF and IF_ID; insert a bubble into ID_EXE.
REQ-013 SHALL have `flush`  out  1: kill the contents of IF_ID and ID_EXE.
REQ-014 SHALL have `fwd_a`, `fwd_b`  out  $clog2(NSTAGES+1) each: 0 = register file, k = result of scoreboard entry k-1.
REQ-015 SHALL have `fetch_en`  out  1: IF may advance the PC.
REQ-016 SHALL have `halt`  out  1: the pipeline has drained after a HALT.

Function
REQ-017 SHALL keep a scoreboard of NSTAGES entries {valid, rd, load}; entry 0 = EXE, entry NSTAGES-1 = WB; it shifts by one position every cycle.
REQ-018 SHALL load entry 0 with {id_valid & id_rd_en & (id_rd != 0), id_rd, id_is_load} when there is no stall and no flush; otherwise entry 0 SHALL get a bubble (valid = 0).
REQ-019 SHALL treat a source as matching entry k only when: the source is enabled, the address is non-zero, entry k is valid and entry k rd equals the source address.
REQ-020 SHALL, when FWD_EN = 0, drive stall = 1 when id_valid is high and either source matches any entry.
REQ-021 SHALL, when FWD_EN = 1, drive stall = 1 only when id_valid is high and a source matches entry 0 and entry 0 load = 1 (one bubble per load-use).
REQ-022 SHALL, when FWD_EN = 1, select fwd_a/fwd_b = 1 + index of the lowest matching entry (youngest producer), or 0 when no entry matches.
REQ-023 SHALL hold fwd_a/fwd_b at 0 when FWD_EN = 0.
REQ-024 SHALL, for the stall and forwarding outputs, be combinational from the inputs and scoreboard state, i.e. zero-cycle latency.
REQ-025 SHALL set flush = exe_br_taken, combinationally.
REQ-026 SHALL give flush priority when flush and stall occur in the same cycle: stall is forced to 0.
REQ-027 SHALL implement the halt FSM with states RUN, DRAIN and HALTED.
REQ-028 SHALL go from RUN to DRAIN when id_valid & id_is_halt & !stall & !flush; a halt that is flushed SHALL leave the FSM in RUN.
REQ-029 SHALL, in DRAIN, load a counter with NSTAGES, decrement it each cycle, and enter HALTED on the cycle after it reaches 1.
REQ-030 SHALL stay in HALTED until reset.
REQ-031 SHALL drive fetch_en = 1 only in RUN.
REQ-032 SHALL drive halt = 1 only in HALTED.
REQ-033 SHALL ignore exe_br_taken in DRAIN and HALTED (flush = 0 there); exe_br_taken there is illegal and SHALL trigger a simulation assertion.
REQ-034 SHALL, in HALTED, keep stall = 0 and accept only bubbles into the scoreboard.

Reset
REQ-035 SHALL, while rst_n = 0, asynchronously clear all scoreboard valid bits, set the FSM to RUN and clear the drain counter.
REQ-036 SHALL give these output values in reset: stall = 0, flush = 0, fwd_a = fwd_b = 0, fetch_en = 1, halt = 0.
REQ-037 SHALL abandon a drain in progress on reset, with no halt asserted.

Structure
REQ-038 SHALL place the FSM state encodings (RUN, DRAIN, HALTED) and the fwd value for "register file" in the shared params.v.
REQ-039 SHALL contain one sub-module, pipe_scoreboard: the parametrised shift register with a per-entry match output for each source.

Verification
REQ-040 SHALL cover stall-only mode: FWD_EN = 0, ADD r3 then SUB r4,r3,r1 -> stall high 3 cycles, then SUB issues with fwd_a = 0.
REQ-041 SHALL cover forwarding: FWD_EN = 1, ADD r3 then SUB r4,r3,r3 -> no stall, fwd_a = fwd_b = 1; with one instruction between them -> fwd = 2.
REQ-042 SHALL cover load-use: LD r5 then ADD r6,r5,r0 -> exactly 1 stall cycle, then fwd_a = 2 and fwd_b = 0.
REQ-043 SHALL cover register 0: writer of r0 followed by a reader of r0 -> no stall, fwd = 0.
REQ-044 SHALL cover branch against halt: exe_br_taken in the same cycle as HALT in ID during a load-use stall -> flush = 1, stall = 0, FSM stays RUN.
REQ-045 SHALL cover halt drain: HALT issued, NSTAGES = 3 -> fetch_en low the next cycle, halt high 4 cycles after issue; rst_n pulse mid-drain -> halt = 0, fetch_en = 1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: halt FSM states and forward-select codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_hazard_ctrl_pkg;

  // Halt sequencing: RUN -> DRAIN (in-flight instructions retire) -> HALTED.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_e;

  // Forward-select value meaning "take the operand from the register file".
  localparam int unsigned FWD_RF = 0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard request bundle and the controller's pipeline-control responses.
// Latency: n/a (wiring only).
// Backpressure: stall from the controller holds IF/IF_ID; flush kills IF_ID/ID_EXE.
// Ports: master = pipeline side (drives ID info, consumes controls);
//        slave  = hazard controller (consumes ID info, drives controls).
interface pipe_hazard_ctrl_if #(
  parameter int NSTAGES      = 3,
  parameter int REG_ADDR_LEN = 5
);
  localparam int FW = $clog2(NSTAGES + 1);

  logic                    id_valid;
  logic [REG_ADDR_LEN-1:0] id_rs1;
  logic [REG_ADDR_LEN-1:0] id_rs2;
  logic                    id_rs1_en;
  logic                    id_rs2_en;
  logic [REG_ADDR_LEN-1:0] id_rd;
  logic                    id_rd_en;
  logic                    id_is_load;
  logic                    id_is_halt;
  logic                    exe_br_taken;

  logic                    stall;
  logic                    flush;
  logic [FW-1:0]           fwd_a;
  logic [FW-1:0]           fwd_b;
  logic                    fetch_en;
  logic                    halt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rd, id_rd_en,
           id_is_load, id_is_halt, exe_br_taken,
    input  stall, flush, fwd_a, fwd_b, fetch_en, halt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rd, id_rd_en,
           id_is_load, id_is_halt, exe_br_taken,
    output stall, flush, fwd_a, fwd_b, fetch_en, halt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Shift-register scoreboard of in-flight destinations (entry 0 = EXE ... NSTAGES-1 = WB).
// Latency: push visible in entry 0 the cycle after; match outputs are combinational.
// Backpressure: none; shifts every cycle, a bubble is pushed as push_vld = 0.
// Ports: clk/rst_n; i_push_* = new entry 0; i_rs*/i_rs*_en = ID sources;
//        o_match_a/b = per-entry source hit; o_load0 = entry 0 is a load.
module pipe_scoreboard #(
  parameter int NSTAGES      = 3,
  parameter int REG_ADDR_LEN = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_push_vld,
  input  logic [REG_ADDR_LEN-1:0] i_push_rd,
  input  logic                    i_push_load,
  input  logic [REG_ADDR_LEN-1:0] i_rs1,
  input  logic                    i_rs1_en,
  input  logic [REG_ADDR_LEN-1:0] i_rs2,
  input  logic                    i_rs2_en,
  output logic [NSTAGES-1:0]      o_match_a,
  output logic [NSTAGES-1:0]      o_match_b,
  output logic                    o_load0
);
  logic [NSTAGES-1:0]      r_vld;
  logic [NSTAGES-1:0]      r_load;
  logic [REG_ADDR_LEN-1:0] r_rd [NSTAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_load <= '0;
      for (int k = 0; k < NSTAGES; k++) r_rd[k] <= '0;
    end else begin
      r_vld  <= {r_vld[NSTAGES-2:0], i_push_vld};
      r_load <= {r_load[NSTAGES-2:0], i_push_load};
      r_rd[0] <= i_push_rd;
      for (int k = 1; k < NSTAGES; k++) r_rd[k] <= r_rd[k-1];
    end
  end

  // r0 is hardwired zero, so it never creates a dependency.
  always_comb begin
    o_match_a = '0;
    o_match_b = '0;
    for (int k = 0; k < NSTAGES; k++) begin
      o_match_a[k] = i_rs1_en && (i_rs1 != '0) && r_vld[k] && (r_rd[k] == i_rs1);
      o_match_b[k] = i_rs2_en && (i_rs2 != '0) && r_vld[k] && (r_rd[k] == i_rs2);
    end
  end

  assign o_load0 = r_load[0];
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RAW stall/forward selection, branch flush, halt drain FSM.
// Latency: stall/flush/fwd combinational (0 cycles); fetch_en drops 1 cycle after HALT issues.
// Backpressure: stall holds IF/IF_ID and bubbles ID_EXE; flush overrides stall.
// Ports: clk, rst_n (async active-low); hz = slave side of pipe_hazard_ctrl_if.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NSTAGES      = 3,
  parameter int REG_ADDR_LEN = 5,
  parameter int FWD_EN       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int FW = $clog2(NSTAGES + 1);

  hz_state_e          r_state, w_state_nxt;
  logic [FW-1:0]      r_cnt, w_cnt_nxt;
  logic [NSTAGES-1:0] w_match_a, w_match_b;
  logic               w_load0;
  logic               w_run, w_halted, w_flush, w_stall, w_push;
  logic [FW-1:0]      w_fwd_a, w_fwd_b;

  assign w_run    = (r_state == RUN);
  assign w_halted = (r_state == HALTED);

  // Branches are only legal while running; rst_n gating keeps flush low in reset.
  assign w_flush = rst_n & w_run & hz.exe_br_taken;

  always_comb begin
    w_stall = 1'b0;
    if (FWD_EN == 0)
      w_stall = hz.id_valid & ((|w_match_a) | (|w_match_b));
    else
      // Only a load one stage ahead cannot be forwarded in time.
      w_stall = hz.id_valid & w_load0 & (w_match_a[0] | w_match_b[0]);
    if (w_flush || w_halted) w_stall = 1'b0;
  end

  // Walk oldest to youngest so the youngest producer wins.
  always_comb begin
    w_fwd_a = FW'(FWD_RF);
    w_fwd_b = FW'(FWD_RF);
    if (FWD_EN != 0) begin
      for (int k = NSTAGES - 1; k >= 0; k--) begin
        if (w_match_a[k]) w_fwd_a = FW'(k + 1);
        if (w_match_b[k]) w_fwd_b = FW'(k + 1);
      end
    end
  end

  assign w_push = hz.id_valid & hz.id_rd_en & (hz.id_rd != '0)
                & ~w_stall & ~w_flush & ~w_halted;

  pipe_scoreboard #(
    .NSTAGES      (NSTAGES),
    .REG_ADDR_LEN (REG_ADDR_LEN)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push_vld  (w_push),
    .i_push_rd   (hz.id_rd),
    .i_push_load (hz.id_is_load),
    .i_rs1       (hz.id_rs1),
    .i_rs1_en    (hz.id_rs1_en),
    .i_rs2       (hz.id_rs2),
    .i_rs2_en    (hz.id_rs2_en),
    .o_match_a   (w_match_a),
    .o_match_b   (w_match_b),
    .o_load0     (w_load0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The drain counter is loaded as the HALT leaves ID, so HALTED is reached
  // NSTAGES+1 cycles after issue, once the HALT has passed WB.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RUN: begin
        if (hz.id_valid && hz.id_is_halt && !w_stall && !w_flush) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = FW'(NSTAGES);
        end
      end
      DRAIN: begin
        if (r_cnt == FW'(1)) begin
          w_state_nxt = HALTED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - FW'(1);
        end
      end
      default: w_state_nxt = r_state;
    endcase
  end

  assign hz.stall    = w_stall;
  assign hz.flush    = w_flush;
  assign hz.fwd_a    = w_fwd_a;
  assign hz.fwd_b    = w_fwd_b;
  assign hz.fetch_en = w_run;
  assign hz.halt     = w_halted;

  // A taken branch cannot exist behind a HALT that has already issued.
  a_no_br_after_halt: assert property (@(posedge clk) disable iff (!rst_n)
    !(hz.exe_br_taken && !w_run));
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: stall-only DUT (u0) and forwarding DUT (u1), both NSTAGES = 3.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic       rs1_en;
    logic [4:0] rs2;
    logic       rs2_en;
    logic [4:0] rd;
    logic       rd_en;
    logic       ld;
    logic       hlt;
    logic       br;
  } id_t;

  id_t d0, d1;

  pipe_hazard_ctrl_if #(.NSTAGES(3), .REG_ADDR_LEN(5)) if0 ();
  pipe_hazard_ctrl_if #(.NSTAGES(3), .REG_ADDR_LEN(5)) if1 ();

  assign if0.id_valid = d0.valid;  assign if1.id_valid = d1.valid;
  assign if0.id_rs1 = d0.rs1;      assign if1.id_rs1 = d1.rs1;
  assign if0.id_rs1_en = d0.rs1_en; assign if1.id_rs1_en = d1.rs1_en;
  assign if0.id_rs2 = d0.rs2;      assign if1.id_rs2 = d1.rs2;
  assign if0.id_rs2_en = d0.rs2_en; assign if1.id_rs2_en = d1.rs2_en;
  assign if0.id_rd = d0.rd;        assign if1.id_rd = d1.rd;
  assign if0.id_rd_en = d0.rd_en;  assign if1.id_rd_en = d1.rd_en;
  assign if0.id_is_load = d0.ld;   assign if1.id_is_load = d1.ld;
  assign if0.id_is_halt = d0.hlt;  assign if1.id_is_halt = d1.hlt;
  assign if0.exe_br_taken = d0.br; assign if1.exe_br_taken = d1.br;

  pipe_hazard_ctrl #(.NSTAGES(3), .REG_ADDR_LEN(5), .FWD_EN(0)) u0 (
    .clk(clk), .rst_n(rst_n), .hz(if0.slave));
  pipe_hazard_ctrl #(.NSTAGES(3), .REG_ADDR_LEN(5), .FWD_EN(1)) u1 (
    .clk(clk), .rst_n(rst_n), .hz(if1.slave));

  function automatic id_t ins(input logic [4:0] rd, input logic rd_en,
                              input logic [4:0] rs1, input logic e1,
                              input logic [4:0] rs2, input logic e2,
                              input logic ld, input logic hlt);
    id_t t;
    t = '0;
    t.valid = 1'b1; t.rd = rd; t.rd_en = rd_en;
    t.rs1 = rs1; t.rs1_en = e1; t.rs2 = rs2; t.rs2_en = e2;
    t.ld = ld; t.hlt = hlt;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk);     endtask

  initial begin
    d0 = '0; d1 = '0; rst_n = 1'b0;
    #2;
    chk("rst_stall0", if0.stall, 0);    chk("rst_stall1", if1.stall, 0);
    chk("rst_flush1", if1.flush, 0);    chk("rst_fwda1", if1.fwd_a, 0);
    chk("rst_fwdb1", if1.fwd_b, 0);     chk("rst_fetch0", if0.fetch_en, 1);
    chk("rst_fetch1", if1.fetch_en, 1); chk("rst_halt1", if1.halt, 0);
    @(negedge clk); rst_n = 1'b1;

    // Stall-only: ADD r3 ; SUB r4,r3,r1 -> 3 stall cycles
    next(); d0 = ins(5'd3, 1, 5'd1, 1, 5'd2, 1, 0, 0);
    mid();  chk("so_add_nostall", if0.stall, 0);
    next(); d0 = ins(5'd4, 1, 5'd3, 1, 5'd1, 1, 0, 0);
    mid();  chk("so_stall_c1", if0.stall, 1); chk("so_fwd_zero", if0.fwd_a, 0);
    next(); mid(); chk("so_stall_c2", if0.stall, 1);
    next(); mid(); chk("so_stall_c3", if0.stall, 1);
    next(); mid(); chk("so_issue", if0.stall, 0); chk("so_issue_fwda", if0.fwd_a, 0);
    next(); d0 = '0; repeat (3) next();

    // Forwarding: back-to-back and one-apart, plus youngest/oldest selection
    d1 = ins(5'd3, 1, 5'd1, 1, 5'd2, 1, 0, 0);
    mid(); next(); d1 = ins(5'd4, 1, 5'd3, 1, 5'd3, 1, 0, 0);
    mid(); chk("fw_b2b_stall", if1.stall, 0);
    chk("fw_b2b_a", if1.fwd_a, 1); chk("fw_b2b_b", if1.fwd_b, 1);
    next(); d1 = ins(5'd3, 1, 5'd1, 1, 5'd2, 1, 0, 0);
    next(); d1 = ins(5'd7, 1, 5'd1, 1, 5'd2, 1, 0, 0);
    next(); d1 = ins(5'd4, 1, 5'd3, 1, 5'd3, 1, 0, 0);
    mid(); chk("fw_gap_a", if1.fwd_a, 2); chk("fw_gap_b", if1.fwd_b, 2);
    next(); d1 = ins(5'd0, 0, 5'd3, 1, 5'd4, 1, 0, 0);
    mid(); chk("fw_wb_a", if1.fwd_a, 3); chk("fw_exe_b", if1.fwd_b, 1);
    next(); d1 = '0; repeat (3) next();

    // Load-use: LD r5 ; ADD r6,r5,r0 -> one bubble, then forward from MEM
    d1 = ins(5'd5, 1, 5'd1, 1, 5'd0, 0, 1, 0);
    mid(); next(); d1 = ins(5'd6, 1, 5'd5, 1, 5'd0, 1, 0, 0);
    mid(); chk("lu_stall", if1.stall, 1);
    next(); mid(); chk("lu_release", if1.stall, 0);
    chk("lu_fwda", if1.fwd_a, 2); chk("lu_fwdb", if1.fwd_b, 0);
    next(); d1 = '0; repeat (3) next();

    // Register 0 is never a dependency
    d0 = ins(5'd0, 1, 5'd1, 1, 5'd2, 1, 0, 0); d1 = d0;
    mid(); next(); d0 = ins(5'd8, 1, 5'd0, 1, 5'd0, 1, 0, 0); d1 = d0;
    mid(); chk("r0_stall0", if0.stall, 0); chk("r0_stall1", if1.stall, 0);
    chk("r0_fwda", if1.fwd_a, 0); chk("r0_fwdb", if1.fwd_b, 0);
    next(); d0 = '0; d1 = '0; repeat (3) next();

    // Branch vs HALT during a load-use stall: flush wins, FSM stays in RUN
    d1 = ins(5'd5, 1, 5'd1, 1, 5'd0, 0, 1, 0);
    mid(); next(); d1 = ins(5'd0, 0, 5'd5, 1, 5'd0, 0, 0, 1); d1.br = 1'b1;
    mid(); chk("bh_flush", if1.flush, 1); chk("bh_stall", if1.stall, 0);
    next(); d1 = '0;
    mid(); chk("bh_flush_off", if1.flush, 0);
    chk("bh_fetch", if1.fetch_en, 1); chk("bh_halt", if1.halt, 0);
    repeat (3) next();

    // HALT drain on u1: fetch_en drops next cycle, halt 4 cycles after issue
    d1 = ins(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);
    mid(); chk("hd_issue_fetch", if1.fetch_en, 1);
    next(); d1 = '0;
    mid(); chk("hd_c1_fetch", if1.fetch_en, 0); chk("hd_c1_halt", if1.halt, 0);
    next(); mid(); chk("hd_c2_halt", if1.halt, 0);
    next(); mid(); chk("hd_c3_halt", if1.halt, 0);
    next(); mid(); chk("hd_c4_halt", if1.halt, 1); chk("hd_c4_fetch", if1.fetch_en, 0);
    // In HALTED nothing enters the scoreboard, so no hazard can form
    next(); d1 = ins(5'd9, 1, 5'd1, 1, 5'd0, 0, 1, 0);
    next(); d1 = ins(5'd10, 1, 5'd9, 1, 5'd0, 0, 0, 0);
    mid(); chk("ht_stall", if1.stall, 0); chk("ht_fwda", if1.fwd_a, 0);
    chk("ht_hold", if1.halt, 1);
    next(); d1 = '0; rst_n = 1'b0; #1;
    chk("ht_rst_halt", if1.halt, 0); chk("ht_rst_fetch", if1.fetch_en, 1);
    @(negedge clk); rst_n = 1'b1;

    // Reset pulse mid-drain on u0 abandons the halt
    next(); d0 = ins(5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);
    mid(); chk("md_issue_stall", if0.stall, 0);
    next(); d0 = '0;
    mid(); chk("md_c1_fetch", if0.fetch_en, 0);
    next(); mid(); rst_n = 1'b0; #1;
    chk("md_rst_fetch", if0.fetch_en, 1); chk("md_rst_halt", if0.halt, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) next();
    mid(); chk("md_after_halt", if0.halt, 0); chk("md_after_fetch", if0.fetch_en, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
